// File: rtl/div_sign_sequencer_pkg.sv
// Shared types and constants for the signed/unsigned divide front end.
package div_sign_sequencer_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = '1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    FIXUP,
    DONE
  } state_t;

endpackage

// File: rtl/div_sign_sequencer_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_value
);

  assign o_value = i_neg ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/div_sign_sequencer.sv
// Request/response front end for an unsigned sequential divider: sign handling,
// divide-by-zero / overflow bypass, rising-edge completion detect and timeout.
module div_sign_sequencer
  import div_sign_sequencer_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_dz,
  output logic             rsp_err,
  output logic             div_run,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);

  localparam int                CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;
  logic             r_err;
  logic             r_ready_d;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_ready_rise;
  logic             w_timeout;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_div_zero   = (req_divisor == '0);
  assign w_overflow   = req_signed && (req_dividend == DIV_INT_MIN) &&
                        (req_divisor == DIV_ALL_ONES);
  // A Ready still high from an earlier operation must not count as completion.
  assign w_ready_rise = div_ready && !r_ready_d;
  assign w_timeout    = (r_cnt == CNT_LAST);

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .i_value (r_dividend),
    .i_neg   (r_sa),
    .o_value (div_dividend)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .i_value (r_divisor),
    .i_neg   (r_sb),
    .o_value (div_divisor)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .i_value (r_q),
    .i_neg   (r_sa ^ r_sb),
    .o_value (w_fix_q)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .i_value (r_r),
    .i_neg   (r_sa),
    .o_value (w_fix_r)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    div_run   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = (w_div_zero || w_overflow) ? DONE : START;
        end
      end
      START: begin
        div_run = 1'b1;
        w_next  = WAIT;
      end
      WAIT: begin
        if (w_ready_rise) begin
          w_next = FIXUP;
        end else if (w_timeout) begin
          w_next = DONE;
        end
      end
      FIXUP: w_next = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_dz       <= 1'b0;
      r_err      <= 1'b0;
      r_ready_d  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ready_d <= div_ready;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dividend <= req_dividend;
            r_divisor  <= req_divisor;
            r_sa       <= req_signed && req_dividend[WIDTH-1];
            r_sb       <= req_signed && req_divisor[WIDTH-1];
            if (w_div_zero) begin
              r_q  <= DIV_ALL_ONES;
              r_r  <= req_dividend;
              r_dz <= 1'b1;
            end else if (w_overflow) begin
              r_q <= DIV_INT_MIN;
              r_r <= '0;
            end
          end
        end
        START: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_ready_rise) begin
            r_q <= div_quotient;
            r_r <= div_remainder;
          end else if (w_timeout) begin
            r_q   <= '0;
            r_r   <= '0;
            r_err <= 1'b1;
          end
        end
        FIXUP: begin
          r_q <= w_fix_q;
          r_r <= w_fix_r;
        end
        DONE: begin
          if (rsp_ready) begin
            r_dz  <= 1'b0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_quotient  = r_q;
  assign rsp_remainder = r_r;
  assign rsp_dz        = r_dz;
  assign rsp_err       = r_err;

endmodule

// File: tb/tb_div_sign_sequencer.sv
// Self-checking bench: behavioural divider responder plus an arithmetic reference model.
module tb_div_sign_sequencer;
  import div_sign_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_signed = 1'b0;
  logic [31:0] req_dividend = '0;
  logic [31:0] req_divisor = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_quotient;
  logic [31:0] rsp_remainder;
  logic        rsp_dz;
  logic        rsp_err;
  logic        div_run;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_ready = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;

  always #5 clk = ~clk;

  div_sign_sequencer #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_signed    (req_signed),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dz        (rsp_dz),
    .rsp_err       (rsp_err),
    .div_run       (div_run),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_ready     (div_ready),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Divider responder. Mode 0: normal, random latency. Mode 1: Ready stuck low.
  // Mode 2: Ready idles high with junk data, stays high after Run, then drops and rises with the result.
  int          m_mode = 0;
  int          m_cnt = 0;
  int          run_count = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  bit          stab_err = 1'b0;

  always @(posedge clk) begin
    if (div_run) begin
      run_count <= run_count + 1;
      m_a       <= div_dividend;
      m_b       <= div_divisor;
      case (m_mode)
        0: begin
          div_ready <= 1'b0;
          m_cnt     <= int'($urandom_range(1, 6));
        end
        1: begin
          div_ready <= 1'b0;
          m_cnt     <= 0;
        end
        default: m_cnt <= 5;
      endcase
    end else if (m_cnt > 0) begin
      if (div_dividend !== m_a || div_divisor !== m_b) stab_err <= 1'b1;
      m_cnt <= m_cnt - 1;
      if (m_mode == 2 && m_cnt == 2) div_ready <= 1'b0;
      if (m_cnt == 1) begin
        div_ready     <= 1'b1;
        div_quotient  <= m_a / m_b;
        div_remainder <= m_a % m_b;
      end
    end else if (m_mode == 2) begin
      div_ready     <= 1'b1;
      div_quotient  <= 32'hDEAD_BEEF;
      div_remainder <= 32'h0BAD_F00D;
    end
  end

  // Reference: truncating division, remainder follows the dividend, results modulo 2^32.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit dz, output bit byp);
    longint sa;
    longint sb;
    dz  = 1'b0;
    byp = 1'b0;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dz  = 1'b1;
      byp = 1'b1;
    end else if (sgn) begin
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      q   = 32'(sa / sb);
      r   = 32'(sa % sb);
      byp = (a == DIV_INT_MIN) && (b == DIV_ALL_ONES);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [31:0] mag(input bit sgn, input logic [31:0] x);
    longint v;
    v = longint'(signed'(x));
    if (sgn && v < 0) return 32'(-v);
    return x;
  endfunction

  task automatic run_txn(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    bit          edz;
    bit          byp;
    int          runs0;
    int          cyc;
    ref_div(sgn, a, b, eq, er, edz, byp);
    @(negedge clk);
    check({tag, "_req_ready"}, req_ready, 1);
    req_valid    = 1'b1;
    req_signed   = sgn;
    req_dividend = a;
    req_divisor  = b;
    rsp_ready    = 1'b0;
    runs0        = run_count;
    @(posedge clk);
    @(negedge clk);
    cyc          = 1;
    req_valid    = 1'($urandom_range(0, 1));
    req_signed   = 1'($urandom_range(0, 1));
    req_dividend = $urandom;
    req_divisor  = $urandom;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
      req_dividend = $urandom;
    end
    req_valid = 1'b0;
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    if (byp) check({tag, "_bypass_latency"}, 64'(cyc), 1);
    else     check({tag, "_min_latency"}, (cyc >= 4), 1);
    check({tag, "_q"}, rsp_quotient, eq);
    check({tag, "_r"}, rsp_remainder, er);
    check({tag, "_dz"}, rsp_dz, edz);
    check({tag, "_err"}, rsp_err, 0);
    check({tag, "_runs"}, 64'(run_count - runs0), byp ? 1'b0 : 1'b1);
    if (!byp) begin
      check({tag, "_div_a"}, m_a, mag(sgn, a));
      check({tag, "_div_b"}, m_b, mag(sgn, b));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_qr"}, {rsp_quotient, rsp_remainder}, {eq, er});
      check({tag, "_hold_flags"}, {rsp_valid, req_ready, rsp_dz}, {1'b1, 1'b0, edz});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_after_ack"}, {rsp_valid, req_ready, rsp_dz, rsp_err}, 4'b0100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(negedge clk);
    check("reset_handshake", {req_ready, rsp_valid, div_run}, 3'b100);
    check("reset_flags", {rsp_dz, rsp_err}, 2'b00);
    check("reset_rsp_data", {rsp_quotient, rsp_remainder}, 64'd0);
    check("reset_div_data", {div_dividend, div_divisor}, 64'd0);
    rst_n = 1'b1;

    run_txn(1'b0, 32'd100, 32'd7, 0, "u_100_7");
    run_txn(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "s_m7_2");
    run_txn(1'b1, 32'd7, 32'hFFFF_FFFE, 3, "s_7_m2");
    run_txn(1'b0, 32'd5, 32'd0, 0, "dz_unsigned");
    run_txn(1'b1, 32'd5, 32'd0, 3, "dz_signed");
    run_txn(1'b1, DIV_INT_MIN, DIV_ALL_ONES, 0, "ovf_signed");
    run_txn(1'b0, DIV_INT_MIN, DIV_ALL_ONES, 0, "ovf_pattern_unsigned");

    m_mode = 2;
    repeat (3) @(negedge clk);
    run_txn(1'b1, 32'hFFFF_FF9C, 32'd9, 0, "stale_ready");
    m_mode = 0;

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? DIV_INT_MIN : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'(-$urandom_range(1, 15));
        3:       b = DIV_ALL_ONES;
        default: b = $urandom;
      endcase
      run_txn(sgn, a, b, int'($urandom_range(0, 2)), "random");
    end

    // Divider never completes: expect the timeout response.
    m_mode = 1;
    @(negedge clk);
    req_valid    = 1'b1;
    req_signed   = 1'b1;
    req_dividend = 32'd100;
    req_divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc       = 1;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_valid", rsp_valid, 1);
    check("timeout_window", (cyc >= 64 && cyc <= 68), 1);
    check("timeout_flags", {rsp_err, rsp_dz}, 2'b10);
    check("timeout_qr", {rsp_quotient, rsp_remainder}, 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("timeout_after_ack", {rsp_valid, req_ready, rsp_err}, 3'b010);

    // Asynchronous reset while waiting on the divider.
    @(negedge clk);
    req_valid    = 1'b1;
    req_signed   = 1'b1;
    req_dividend = 32'hFFFF_0000;
    req_divisor  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {req_ready, rsp_valid}, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_handshake", {req_ready, rsp_valid, div_run}, 3'b100);
    check("async_reset_flags", {rsp_dz, rsp_err}, 2'b00);
    check("async_reset_div_data", {div_dividend, div_divisor}, 64'd0);
    check("async_reset_rsp_data", {rsp_quotient, rsp_remainder}, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_mode = 0;
    run_txn(1'b1, 32'hFFFF_FF00, 32'd16, 1, "after_reset");

    check("operand_stability", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sign_sequencer.md
Name: div_sign_sequencer

Overview:
- Request/response front end for the 32-bit unsigned sequential divider (Run/Ready, Dividend/Divisor in, Quotient/Remainder out).
- Accepts signed or unsigned divide requests on a valid/ready handshake and converts operands to magnitudes.
- Drives the divider's Run, waits for its Ready, then applies sign fix-up.
- Resolves divide-by-zero and signed overflow locally without starting the divider, and returns results on a valid/ready response port.

Parameters:
- WIDTH, 32, operand/result width; must match the divider.
- TIMEOUT, 64, maximum cycles in WAIT before the operation is aborted with rsp_err.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_signed  in  1  1 = two's-complement divide, 0 = unsigned.
- req_dividend  in  WIDTH  dividend.
- req_divisor  in  WIDTH  divisor.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_quotient  out  WIDTH  final quotient.
- rsp_remainder  out  WIDTH  final remainder.
- rsp_dz  out  1  divide-by-zero flag.
- rsp_err  out  1  divider timeout flag.
- div_run  out  1  one-cycle start pulse to the divider.
- div_dividend  out  WIDTH  magnitude dividend to the divider; held stable from START until the result is captured.
- div_divisor  out  WIDTH  magnitude divisor to the divider; same stability rule.
- div_ready  in  1  divider done.
- div_quotient  in  WIDTH  unsigned quotient from the divider.
- div_remainder  in  WIDTH  unsigned remainder from the divider.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE.
  - req_ready=1; rsp_valid=0; div_run=0; rsp_dz=0; rsp_err=0.
  - All data outputs=0.
  - Timeout counter=0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, register operands and the sign flags (sa=signed&&dividend[MSB], sb=signed&&divisor[MSB]).
    - Divisor==0 -> DONE with q=all-ones, r=dividend, rsp_dz=1.
    - Signed, dividend=0x80000000, divisor=all-ones -> DONE with q=0x80000000, r=0.
    - Otherwise -> START.
  - START (1 cycle): div_run=1; div_dividend=|dividend|, div_divisor=|divisor| (negated when the sign flag is set). Clear the timeout counter. -> WAIT.
  - WAIT: div_run=0. The counter increments each cycle.
    - Capture div_quotient/div_remainder only on a rising edge of div_ready (div_ready=1 with the previous sample 0). A Ready left high from a prior operation is never taken as completion. -> FIXUP.
    - Counter reaching TIMEOUT -> DONE with q=0, r=0, rsp_err=1.
  - FIXUP (1 cycle):
    - q = (sa^sb) ? -q : q.
    - r = sa ? -r : r.
    - Truncating division; the remainder takes the dividend's sign; arithmetic is modulo 2^WIDTH.
    - -> DONE.
  - DONE: rsp_valid=1; outputs held stable while rsp_ready=0. On rsp_valid&&rsp_ready -> IDLE, clearing rsp_dz and rsp_err.
- req_ready=1 only in IDLE. No request is accepted in the same cycle a response completes.
- Latency from accept edge to rsp_valid:
  - Bypass (divide-by-zero, overflow): 1 cycle.
  - Normal: 3 cycles + divider time.
- Unsigned mode: sa=sb=0, so no negation is applied.
- A Reset assertion mid-operation aborts immediately to IDLE. The divider is not notified; its stale Ready is ignored by the rising-edge rule.
- Inputs on the req_ bus are ignored outside IDLE.

Decomposition:
- Shared package holds:
  - State enum (IDLE, START, WAIT, FIXUP, DONE).
  - WIDTH default.
  - Constants DIV_INT_MIN (0x80000000) and DIV_ALL_ONES.
- One sub-module: div_sign_fix. Combinational two's-complement conditional negate (in, neg -> out), instantiated for operand magnitude conversion and for result fix-up.
- Timeout counter and FSM stay in the top level.

Test Plan:
- Unsigned 100/7 (req_signed=0) -> one div_run pulse with 100/7; rsp_quotient=14, rsp_remainder=2, rsp_dz=0, rsp_err=0.
- Signed -7/2 (0xFFFFFFF9/0x2) -> divider sees 7/2; rsp_quotient=0xFFFFFFFD, rsp_remainder=0xFFFFFFFF. Also 7/-2 -> q=0xFFFFFFFD, r=1.
- Divide by zero, 5/0 in both modes -> no div_run; rsp_valid one cycle after accept; q=0xFFFFFFFF, r=5, rsp_dz=1.
- Signed overflow 0x80000000/0xFFFFFFFF -> no div_run; q=0x80000000, r=0, rsp_dz=0.
- Back-pressure: rsp_ready=0 for 3 cycles after rsp_valid -> outputs stable and req_ready=0 throughout. Accept -> next cycle req_ready=1, rsp_valid=0.
- Robustness, three parts:
  - div_ready held high before START -> no capture until it falls and rises.
  - div_ready stuck low -> after TIMEOUT=64 cycles, rsp_err=1 with q=r=0.
  - Reset pulsed low in WAIT -> asynchronous return to the reset values.
